// File: rtl/alu_exec.sv
// rtl/alu_exec.sv - MIPS execute-stage ALU with valid/ready handshake and a 2-entry result buffer
module alu_exec #(
    parameter int NBITS = 32,
    parameter int ALUOP = 4,
    parameter int DEPTH = 2
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [ALUOP-1:0] i_ALUOp,
    input  logic [NBITS-1:0] i_A,
    input  logic [NBITS-1:0] i_B,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [NBITS-1:0] o_Result,
    output logic             o_Zero,
    output logic             o_Overflow,
    output logic             o_Error
);

    localparam logic [ALUOP-1:0] OP_AND = ALUOP'(4'b0000);
    localparam logic [ALUOP-1:0] OP_OR  = ALUOP'(4'b0001);
    localparam logic [ALUOP-1:0] OP_ADD = ALUOP'(4'b0010);
    localparam logic [ALUOP-1:0] OP_SUB = ALUOP'(4'b0110);
    localparam logic [ALUOP-1:0] OP_SLT = ALUOP'(4'b0111);
    localparam logic [ALUOP-1:0] OP_NOR = ALUOP'(4'b1100);
    localparam logic [ALUOP-1:0] OP_XOR = ALUOP'(4'b1101);

    typedef struct packed {
        logic [NBITS-1:0] result;
        logic             zero;
        logic             ovf;
        logic             err;
    } entry_t;

    entry_t           buf_q [DEPTH];
    logic             rd_ptr_q, wr_ptr_q;
    logic [1:0]       count_q, count_d;
    entry_t           alu_d;
    entry_t           head;
    logic [NBITS-1:0] sum, diff;
    logic             push, pop;

    assign sum  = i_A + i_B;
    assign diff = i_A - i_B;

    always_comb begin
        alu_d = '0;
        unique case (i_ALUOp)
            OP_AND: alu_d.result = i_A & i_B;
            OP_OR:  alu_d.result = i_A | i_B;
            OP_ADD: begin
                alu_d.result = sum;
                alu_d.ovf    = (i_A[NBITS-1] == i_B[NBITS-1]) && (sum[NBITS-1] != i_A[NBITS-1]);
            end
            OP_SUB: begin
                alu_d.result = diff;
                alu_d.ovf    = (i_A[NBITS-1] != i_B[NBITS-1]) && (diff[NBITS-1] != i_A[NBITS-1]);
            end
            // True signed compare so a wrapped difference cannot flip the answer
            OP_SLT: alu_d.result = {{(NBITS-1){1'b0}}, ($signed(i_A) < $signed(i_B))};
            OP_NOR: alu_d.result = ~(i_A | i_B);
            OP_XOR: alu_d.result = i_A ^ i_B;
            default: alu_d.err = 1'b1;
        endcase
        alu_d.zero = (alu_d.result == '0);
    end

    assign o_ready = (count_q != 2'd2);
    assign o_valid = (count_q != 2'd0);
    assign push    = i_valid && o_ready;
    assign pop     = o_valid && i_ready;

    always_comb begin
        count_d = count_q;
        if (push && !pop)
            count_d = count_q + 2'd1;
        else if (pop && !push)
            count_d = count_q - 2'd1;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            count_q  <= 2'd0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
        end else begin
            if (push) begin
                buf_q[wr_ptr_q] <= alu_d;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop)
                rd_ptr_q <= ~rd_ptr_q;
            count_q <= count_d;
        end
    end

    // Empty buffer presents all-zero fields rather than a stale entry
    assign head       = o_valid ? buf_q[rd_ptr_q] : '0;
    assign o_Result   = head.result;
    assign o_Zero     = head.zero;
    assign o_Overflow = head.ovf;
    assign o_Error    = head.err;

endmodule

// File: tb/tb_alu_exec.sv
// tb/tb_alu_exec.sv - table-driven and scoreboard checks for alu_exec
module tb_alu_exec;

    logic        i_clk, i_reset, i_valid, o_ready, o_valid, i_ready;
    logic [3:0]  i_ALUOp;
    logic [31:0] i_A, i_B, o_Result;
    logic        o_Zero, o_Overflow, o_Error;

    int n_checks = 0;
    int n_fail   = 0;

    alu_exec #(.NBITS(32), .ALUOP(4), .DEPTH(2)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_valid(i_valid), .o_ready(o_ready),
        .i_ALUOp(i_ALUOp), .i_A(i_A), .i_B(i_B), .o_valid(o_valid), .i_ready(i_ready),
        .o_Result(o_Result), .o_Zero(o_Zero), .o_Overflow(o_Overflow), .o_Error(o_Error)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a, b, res;
        logic        z, o, e;
    } vec_t;

    typedef struct packed {
        logic [31:0] r;
        logic        z, o, e;
    } exp_t;

    vec_t vecs[18];
    exp_t q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference built on 64-bit signed arithmetic, independent of sign-bit tricks
    function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t   x;
        longint sa, sb, s;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        x  = '0;
        case (op)
            4'b0000: x.r = a & b;
            4'b0001: x.r = a | b;
            4'b0010: begin s = sa + sb; x.r = s[31:0]; x.o = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
            4'b0110: begin s = sa - sb; x.r = s[31:0]; x.o = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
            4'b0111: x.r = (sa < sb) ? 32'd1 : 32'd0;
            4'b1100: x.r = ~(a | b);
            4'b1101: x.r = a ^ b;
            default: x.e = 1'b1;
        endcase
        x.z = (x.r == 32'd0);
        return x;
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0: return 32'h0000_0000;
            1: return 32'h0000_0001;
            2: return 32'hFFFF_FFFF;
            3: return 32'h7FFF_FFFF;
            4: return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        vecs[0]  = '{4'b0010, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1, 1'b0};
        vecs[1]  = '{4'b0110, 32'h00000005, 32'h00000005, 32'h00000000, 1'b1, 1'b0, 1'b0};
        vecs[2]  = '{4'b0111, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{4'b0111, 32'h80000000, 32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{4'b0110, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b0};
        vecs[5]  = '{4'b0010, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 1'b0};
        vecs[6]  = '{4'b0010, 32'h80000000, 32'h80000000, 32'h00000000, 1'b1, 1'b1, 1'b0};
        vecs[7]  = '{4'b0111, 32'h00000001, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 1'b0};
        vecs[8]  = '{4'b0110, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'h80000000, 1'b0, 1'b1, 1'b0};
        vecs[9]  = '{4'b0011, 32'h00000001, 32'h00000002, 32'h00000000, 1'b1, 1'b0, 1'b1};
        vecs[10] = '{4'b0000, 32'h12345678, 32'h0F0F0F0F, 32'h02040608, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{4'b1111, 32'hDEADBEEF, 32'h12345678, 32'h00000000, 1'b1, 1'b0, 1'b1};
        vecs[12] = '{4'b0001, 32'h00000000, 32'h00000000, 32'h00000000, 1'b1, 1'b0, 1'b0};
        vecs[13] = '{4'b1101, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 1'b0};
        vecs[14] = '{4'b1100, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0};
        vecs[15] = '{4'b0111, 32'h7FFFFFFF, 32'h80000000, 32'h00000000, 1'b1, 1'b0, 1'b0};
        vecs[16] = '{4'b0111, 32'h80000000, 32'h80000000, 32'h00000000, 1'b1, 1'b0, 1'b0};
        vecs[17] = '{4'b0110, 32'h00000003, 32'h00000007, 32'hFFFFFFFC, 1'b0, 1'b0, 1'b0};

        i_reset = 1'b1; i_valid = 1'b0; i_ready = 1'b0;
        i_ALUOp = 4'b0; i_A = 32'd0; i_B = 32'd0;
        repeat (2) @(posedge i_clk);
        #1;
        chk("reset_valid", o_valid, 0);
        chk("reset_ready", o_ready, 1);
        chk("reset_result", o_Result, 0);
        chk("reset_zero", o_Zero, 0);
        chk("reset_ovf", o_Overflow, 0);
        chk("reset_err", o_Error, 0);
        @(negedge i_clk) i_reset = 1'b0;

        // Back-to-back beats with downstream always ready
        for (int i = 0; i < 18; i++) begin
            @(negedge i_clk);
            i_valid = 1'b1; i_ready = 1'b1;
            i_ALUOp = vecs[i].op; i_A = vecs[i].a; i_B = vecs[i].b;
            @(posedge i_clk); #1;
            chk($sformatf("vec%0d_valid", i), o_valid, 1);
            chk($sformatf("vec%0d_result", i), o_Result, vecs[i].res);
            chk($sformatf("vec%0d_zero", i), o_Zero, vecs[i].z);
            chk($sformatf("vec%0d_ovf", i), o_Overflow, vecs[i].o);
            chk($sformatf("vec%0d_err", i), o_Error, vecs[i].e);
        end
        @(negedge i_clk) i_valid = 1'b0;
        @(posedge i_clk); #1;
        chk("drain_valid", o_valid, 0);
        chk("drain_result", o_Result, 0);

        // Stall: AND, OR accepted; NOR held off until space frees
        @(negedge i_clk);
        i_ready = 1'b0; i_valid = 1'b1;
        i_A = 32'hF0F0F0F0; i_B = 32'h0FF00FF0; i_ALUOp = 4'b0000;
        @(posedge i_clk); #1;
        chk("stall1_ready", o_ready, 1);
        chk("stall1_head", o_Result, 32'h00F000F0);
        @(negedge i_clk) i_ALUOp = 4'b0001;
        @(posedge i_clk); #1;
        chk("stall2_ready", o_ready, 0);
        chk("stall2_head", o_Result, 32'h00F000F0);
        @(negedge i_clk) i_ALUOp = 4'b1100;
        @(posedge i_clk); #1;
        chk("stall3_ready", o_ready, 0);
        chk("stall3_head_stable", o_Result, 32'h00F000F0);
        @(negedge i_clk) i_ready = 1'b1;
        @(posedge i_clk); #1;
        chk("rel1_ready", o_ready, 1);
        chk("rel1_head", o_Result, 32'hFFF0FFF0);
        @(posedge i_clk); #1;
        chk("rel2_head", o_Result, 32'h000F000F);
        @(negedge i_clk) i_ALUOp = 4'b1101;
        @(posedge i_clk); #1;
        chk("rel3_head", o_Result, 32'hFF00FF00);
        @(negedge i_clk) i_valid = 1'b0;
        @(posedge i_clk); #1;
        chk("rel4_valid", o_valid, 0);

        // Reset flushes a full buffer
        @(negedge i_clk);
        i_ready = 1'b0; i_valid = 1'b1; i_ALUOp = 4'b0010; i_A = 32'd1; i_B = 32'd1;
        repeat (2) @(posedge i_clk);
        #1;
        chk("full_ready", o_ready, 0);
        chk("full_valid", o_valid, 1);
        @(negedge i_clk) begin i_reset = 1'b1; i_ready = 1'b1; end
        @(posedge i_clk); #1;
        chk("flush_valid", o_valid, 0);
        chk("flush_ready", o_ready, 1);
        chk("flush_result", o_Result, 0);
        @(negedge i_clk) begin i_reset = 1'b0; i_valid = 1'b0; end
        repeat (3) @(posedge i_clk);
        #1;
        chk("flush_stale", o_valid, 0);

        // Random stream against the reference model
        for (int c = 0; c < 600; c++) begin
            logic [3:0] ops [8];
            logic will_push, will_pop;
            exp_t h;
            ops = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100, 4'b1101, 4'b1010};
            @(negedge i_clk);
            i_valid = ($urandom_range(0, 3) != 0);
            i_ready = ($urandom_range(0, 2) != 0);
            i_ALUOp = ops[$urandom_range(0, 7)];
            i_A = pick_operand();
            i_B = pick_operand();
            chk("rnd_ready", o_ready, (q.size() != 2));
            chk("rnd_valid", o_valid, (q.size() != 0));
            will_push = i_valid && (q.size() != 2);
            will_pop  = i_ready && (q.size() != 0);
            if (will_pop) begin
                h = q[0];
                chk("rnd_result", o_Result, h.r);
                chk("rnd_flags", {29'd0, o_Zero, o_Overflow, o_Error}, {29'd0, h.z, h.o, h.e});
            end
            @(posedge i_clk);
            if (will_pop) void'(q.pop_front());
            if (will_push) q.push_back(model(i_ALUOp, i_A, i_B));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
